// File: rtl/w0rm_bus_pkg.sv
// rtl/w0rm_bus_pkg.sv - shared W0RM bus initiator states and defaults
package w0rm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } bus_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/w0rm_bus_timeout_counter.sv
// rtl/w0rm_bus_timeout_counter.sv - saturating wait-cycle counter flagging expiry at LIMIT-1
module w0rm_bus_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT) + 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count enabled cycles, restart on clear, stop at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q >= LAST_C);

endmodule

// File: rtl/w0rm_mem_bus_master.sv
// rtl/w0rm_mem_bus_master.sv - single-outstanding load/store initiator for the W0RM peripheral bus
module w0rm_mem_bus_master
    import w0rm_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  mem_clk,
    input  logic                  cpu_reset,
    input  logic                  cpu_req_valid_i,
    output logic                  cpu_req_ready_o,
    input  logic                  cpu_req_write_i,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_req_data_i,
    output logic                  cpu_resp_valid_o,
    output logic [DATA_WIDTH-1:0] cpu_resp_data_o,
    output logic                  cpu_resp_err_o,
    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic                  mem_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    bus_state_e            state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;
    logic                  tmo_expired;

    w0rm_bus_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (mem_clk),
        .rst    (cpu_reset),
        .clear  (state_q == ST_REQ),
        .enable (state_q == ST_WAIT),
        .expired(tmo_expired)
    );

    // Next-state and latch logic; a response in the expiry cycle beats the timeout
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid_i) begin
                    write_d = cpu_req_write_i;
                    addr_d  = cpu_req_addr_i;
                    wdata_d = cpu_req_data_i;
                    if (cpu_req_addr_i[1:0] != 2'b00) begin
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_valid_i) begin
                    resp_data_d = write_q ? '0 : mem_data_i;
                    resp_err_d  = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_expired) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers
    always_ff @(posedge mem_clk) begin
        if (cpu_reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign cpu_req_ready_o  = (state_q == ST_IDLE);
    assign cpu_resp_valid_o = (state_q == ST_RESP);
    assign cpu_resp_data_o  = resp_data_q;
    assign cpu_resp_err_o   = resp_err_q;
    assign mem_valid_o      = (state_q == ST_REQ);
    assign mem_read_o       = mem_valid_o & ~write_q;
    assign mem_write_o      = mem_valid_o & write_q;
    assign mem_addr_o       = mem_valid_o ? addr_q : '0;
    assign mem_data_o       = mem_valid_o ? wdata_q : '0;

endmodule

// File: tb/tb_w0rm_mem_bus_master.sv
// tb/tb_w0rm_mem_bus_master.sv - self-checking bench for w0rm_mem_bus_master
module tb_w0rm_mem_bus_master;

    localparam int TMO = 16;

    logic        mem_clk = 1'b0;
    logic        cpu_reset = 1'b1;
    logic        cpu_req_valid_i = 1'b0;
    logic        cpu_req_ready_o;
    logic        cpu_req_write_i = 1'b0;
    logic [31:0] cpu_req_addr_i = '0;
    logic [31:0] cpu_req_data_i = '0;
    logic        cpu_resp_valid_o;
    logic [31:0] cpu_resp_data_o;
    logic        cpu_resp_err_o;
    logic        mem_valid_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_valid_i = 1'b0;
    logic [31:0] mem_data_i = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [31:0] last_data = '0;
    logic        last_err = 1'b0;

    w0rm_mem_bus_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .mem_clk         (mem_clk),
        .cpu_reset       (cpu_reset),
        .cpu_req_valid_i (cpu_req_valid_i),
        .cpu_req_ready_o (cpu_req_ready_o),
        .cpu_req_write_i (cpu_req_write_i),
        .cpu_req_addr_i  (cpu_req_addr_i),
        .cpu_req_data_i  (cpu_req_data_i),
        .cpu_resp_valid_o(cpu_resp_valid_o),
        .cpu_resp_data_o (cpu_resp_data_o),
        .cpu_resp_err_o  (cpu_resp_err_o),
        .mem_valid_o     (mem_valid_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .mem_addr_o      (mem_addr_o),
        .mem_data_o      (mem_data_o),
        .mem_valid_i     (mem_valid_i),
        .mem_data_i      (mem_data_i)
    );

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One transaction; delay = cycles after T+2 before the peripheral answers, -1 = no responder
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           input int delay, input logic [31:0] rd);
        bit          mis;
        bit          mv;
        bit          exp_err;
        int          resp_cyc;
        logic [31:0] exp_data;
        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            resp_cyc = 1;
            exp_err  = 1'b1;
            exp_data = '0;
        end else if (delay >= 0 && delay <= TMO - 1) begin
            resp_cyc = 3 + delay;
            exp_err  = 1'b0;
            exp_data = wr ? 32'h0 : rd;
        end else begin
            resp_cyc = 2 + TMO;
            exp_err  = 1'b1;
            exp_data = '0;
        end
        @(negedge mem_clk);
        chk("ready_idle", {31'b0, cpu_req_ready_o}, 32'd1);
        chk("resp_valid_idle", {31'b0, cpu_resp_valid_o}, 32'd0);
        chk("resp_data_hold", cpu_resp_data_o, last_data);
        chk("resp_err_hold", {31'b0, cpu_resp_err_o}, {31'b0, last_err});
        cpu_req_valid_i = 1'b1;
        cpu_req_write_i = wr;
        cpu_req_addr_i  = addr;
        cpu_req_data_i  = wd;
        for (int c = 1; c <= resp_cyc; c++) begin
            @(negedge mem_clk);
            cpu_req_valid_i = 1'b0;
            cpu_req_write_i = 1'b0;
            cpu_req_addr_i  = '0;
            cpu_req_data_i  = '0;
            mem_valid_i = (!mis && delay >= 0 && c == 2 + delay);
            mem_data_i  = mem_valid_i ? rd : 32'h0;
            mv = (!mis && c == 1);
            chk("mem_valid", {31'b0, mem_valid_o}, {31'b0, mv});
            chk("mem_read", {31'b0, mem_read_o}, {31'b0, mv & ~wr});
            chk("mem_write", {31'b0, mem_write_o}, {31'b0, mv & wr});
            chk("mem_addr", mem_addr_o, mv ? addr : 32'h0);
            chk("mem_data", mem_data_o, mv ? wd : 32'h0);
            chk("ready_busy", {31'b0, cpu_req_ready_o}, 32'd0);
            chk("resp_valid", {31'b0, cpu_resp_valid_o}, {31'b0, c == resp_cyc});
            if (c == resp_cyc) begin
                chk("resp_data", cpu_resp_data_o, exp_data);
                chk("resp_err", {31'b0, cpu_resp_err_o}, {31'b0, exp_err});
            end
        end
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        last_data = exp_data;
        last_err  = exp_err;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge mem_clk);
        chk("rst_ready", {31'b0, cpu_req_ready_o}, 32'd1);
        chk("rst_resp_valid", {31'b0, cpu_resp_valid_o}, 32'd0);
        chk("rst_resp_data", cpu_resp_data_o, 32'h0);
        chk("rst_resp_err", {31'b0, cpu_resp_err_o}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
        chk("rst_mem_rw", {30'b0, mem_read_o, mem_write_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 32'h0);
        cpu_reset = 1'b0;

        // Directed: aligned load, store, misaligned load
        run_txn(1'b0, 32'h8000_0088, 32'h0, 0, 32'h0000_00A5);
        run_txn(1'b1, 32'h8000_008C, 32'h0000_000F, 0, 32'h0);
        run_txn(1'b0, 32'h8000_0082, 32'h0, 0, 32'h1234_5678);

        // Timeout with a late reply at T+20
        run_txn(1'b0, 32'h9000_0000, 32'h0, -1, 32'h0);
        @(negedge mem_clk);
        chk("late_t19_resp", {31'b0, cpu_resp_valid_o}, 32'd0);
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hDEAD_BEEF;
        @(negedge mem_clk);
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        chk("late_t20_resp", {31'b0, cpu_resp_valid_o}, 32'd0);
        @(negedge mem_clk);
        chk("late_t21_resp", {31'b0, cpu_resp_valid_o}, 32'd0);
        chk("late_t21_err_hold", {31'b0, cpu_resp_err_o}, 32'd1);

        // Response in the expiry cycle wins; then back-to-back single-cycle loads
        run_txn(1'b0, 32'h8000_0010, 32'h0, TMO - 1, 32'h0000_5A5A);
        run_txn(1'b0, 32'h8000_0014, 32'h0, 0, 32'h1111_2222);
        run_txn(1'b0, 32'h8000_0018, 32'h0, 0, 32'h3333_4444);

        // Reset while in WAIT; the reply the cycle after is ignored
        @(negedge mem_clk);
        cpu_req_valid_i = 1'b1;
        cpu_req_addr_i  = 32'h8000_0020;
        @(negedge mem_clk);
        cpu_req_valid_i = 1'b0;
        cpu_req_addr_i  = '0;
        chk("rstw_mem_valid", {31'b0, mem_valid_o}, 32'd1);
        @(negedge mem_clk);
        cpu_reset = 1'b1;
        @(negedge mem_clk);
        cpu_reset   = 1'b0;
        mem_valid_i = 1'b1;
        mem_data_i  = 32'hCAFE_F00D;
        chk("rstw_ready", {31'b0, cpu_req_ready_o}, 32'd1);
        chk("rstw_resp_valid0", {31'b0, cpu_resp_valid_o}, 32'd0);
        chk("rstw_resp_data", cpu_resp_data_o, 32'h0);
        @(negedge mem_clk);
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        chk("rstw_resp_valid1", {31'b0, cpu_resp_valid_o}, 32'd0);
        chk("rstw_ready1", {31'b0, cpu_req_ready_o}, 32'd1);
        last_data = '0;
        last_err  = 1'b0;

        // Randomized transactions against the model
        for (int n = 0; n < 24; n++) begin
            bit          wr;
            logic [31:0] addr;
            int          delay;
            wr    = bit'($urandom_range(0, 1));
            addr  = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
            run_txn(wr, addr, $urandom, delay, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w0rm_mem_bus_master.md
# w0rm_mem_bus_master

Single-outstanding initiator for the W0RM memory-mapped peripheral bus. Accepts load/store requests from the CPU core over a valid/ready handshake, drives a one-cycle bus request (`mem_valid_o` plus read/write strobes), waits for the addressed peripheral's registered response, and returns the data or an error to the core. It sits between the core's load/store stage and the OR-combined peripheral response bus (GPIO, timers, etc.).

## Interface
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width
- `TIMEOUT_CYCLES`, 16, cycles in WAIT with no peripheral response before an error is returned (≥2)
- `mem_clk`  in  1  the single clock
- `cpu_reset`  in  1  reset; synchronous and active-high
- `cpu_req_valid_i`  in  1  core request valid
- `cpu_req_ready_o`  out  1  master can accept a request
- `cpu_req_write_i`  in  1  1 = store, 0 = load
- `cpu_req_addr_i`  in  ADDR_WIDTH  request address
- `cpu_req_data_i`  in  DATA_WIDTH  store data
- `cpu_resp_valid_o`  out  1  one-cycle response strobe
- `cpu_resp_data_o`  out  DATA_WIDTH  load data; 0 for stores and errors
- `cpu_resp_err_o`  out  1  misaligned address or timeout
- `mem_valid_o`  out  1  bus request strobe
- `mem_read_o`, `mem_write_o`  out  1 each  bus direction strobes
- `mem_addr_o`  out  ADDR_WIDTH  bus address
- `mem_data_o`  out  DATA_WIDTH  bus write data
- `mem_valid_i`  in  1  OR of all peripheral response strobes
- `mem_data_i`  in  DATA_WIDTH  OR of all peripheral read data

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `cpu_req_ready_o`=1. On valid&ready, latch write/addr/data. If `addr[1:0]`≠0, go to RESP with err=1, data=0; no bus cycle. Otherwise go to REQ.
- REQ: `mem_valid_o`=1 for exactly one cycle; `mem_read_o`=!write, `mem_write_o`=write; addr/data held from the latch. Next state WAIT; clear the timeout counter.
- WAIT: on `mem_valid_i`, capture `mem_data_i` (loads) or 0 (stores), set err=0, go to RESP. Otherwise increment the counter. When the counter reaches `TIMEOUT_CYCLES`-1 with no response, set err=1, data=0, and go to RESP. If a response and expiry occur in the same cycle, the response wins.
- RESP: `cpu_resp_valid_o`=1 for one cycle, then IDLE. Data and err hold until the next response.
- `mem_valid_i` in IDLE, REQ or RESP (stray or late response after a timeout) is ignored and never produces a response.
- `mem_addr_o`, `mem_data_o`, `mem_read_o` and `mem_write_o` are 0 whenever `mem_valid_o`=0.

## Timing
- Reset values: all outputs 0 except `cpu_req_ready_o`=1 (state IDLE); counter 0.
- Reset mid-transaction: return to IDLE next edge; the pending transaction is dropped with no response. A peripheral reply in the following cycle is ignored.
- Request accepted at edge T: `mem_valid_o` high in cycle T+1. A standard peripheral answers in T+2. The response is captured at the end of T+2, and `cpu_resp_valid_o` is high in T+3. Best-case latency is 3 cycles from acceptance to response, with throughput of one transaction per 4 cycles.
- Misaligned request: `cpu_resp_valid_o` with err in T+1.
- Timeout: response in cycle T+2+`TIMEOUT_CYCLES`.
- `cpu_req_ready_o` is low from T+1 until the cycle after RESP.

## Structure
- Shared package `w0rm_bus_pkg`: state enum localparams (IDLE=0, REQ=1, WAIT=2, RESP=3) and default `TIMEOUT_CYCLES`. Other bus initiators (DMA) reuse these.
- One sub-module, `w0rm_bus_timeout_counter`:
  - inputs: clear, enable; parameter: limit; output: expired.
  - width is `$clog2(TIMEOUT_CYCLES)+1`; saturates at limit.

## Test plan
- Load from 0x80000088 with a model peripheral returning 0x000000A5 in T+2 → `mem_valid_o`/`mem_read_o` high only in T+1 with addr 0x80000088; `cpu_resp_valid_o` in T+3 with data 0xA5, err 0.
- Store 0x0000000F to 0x8000008C, peripheral acks in T+2 → `mem_write_o`=1 and `mem_data_o`=0xF in T+1; response data 0, err 0.
- Load from 0x80000082 (misaligned) → no `mem_valid_o` ever; response in T+1 with err 1, data 0.
- Load to an unmapped address (no responder), TIMEOUT_CYCLES=16 → response in T+18 with err 1, data 0. A late `mem_valid_i` in T+20 produces no response.
- `cpu_reset` asserted in WAIT, peripheral replies the next cycle → no `cpu_resp_valid_o`; `cpu_req_ready_o`=1 the cycle after reset.
- Response arrives in the timeout-expiry cycle → err 0 with peripheral data; back-to-back requests are accepted every 4th cycle.
